// File: rtl/instr_decode_queue.sv
// Decoding instruction queue: RV32I words are split into their fields and a
// sign-extended immediate on the way in, and the decoded entries are held in
// a small circular FIFO. The head entry drives the out_* ports.
module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_fmt,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      funct7;
    logic [4:0]      rs2;
    logic [4:0]      rs1;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          dec;
  logic [31:0]     imm32;
  logic            push;
  logic            pop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  entry_t          slot [DEPTH];
  entry_t          head;
  entry_t          shown;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  // flush wins over both handshakes, so neither pointer moves on a flush cycle
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Decode the incoming word; every RV32I immediate fits in 32 bits and is
  // then sign-extended to XLEN through a signed size cast.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];
    case (in_instr[6:0])
      7'b0110011: begin
        dec.fmt = FMT_R;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        // includes every word whose low two bits are not 2'b11
        dec.fmt = FMT_ILL;
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // One register per queue slot; a slot is written only when it is the
  // current write target of an accepted word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    entry_t entry_reg;

    // capture the decoded word into this slot on push
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (push && (wr_ptr == AW'(gi))) begin
        entry_reg <= dec;
      end
    end

    assign slot[gi] = entry_reg;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating tally of accepted illegal words; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && (dec.fmt == FMT_ILL) && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  // Outputs read zero whenever the queue is empty, which also covers reset.
  assign head        = slot[rd_ptr];
  assign shown       = out_valid ? head : '0;
  assign out_fmt     = shown.fmt;
  assign out_opcode  = shown.opcode;
  assign out_rd      = shown.rd;
  assign out_rs1     = shown.rs1;
  assign out_rs2     = shown.rs2;
  assign out_funct3  = shown.funct3;
  assign out_funct7  = shown.funct7;
  assign out_imm     = shown.imm;
  assign out_illegal = out_valid && (head.fmt == FMT_ILL);

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: a scoreboard of expected decodes
// is filled as words are accepted and drained as the DUT pops them, plus
// directed checks of the reference vectors and of reset/flush/full behaviour.
module tb_instr_decode_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_fmt;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [2:0]  count;
  logic [15:0] illegal_cnt;

  // second instance at XLEN=64
  logic        d2_in_valid;
  logic        d2_in_ready;
  logic [31:0] d2_in_instr;
  logic        d2_out_valid;
  logic        d2_out_ready;
  logic        d2_flush;
  logic [2:0]  d2_out_fmt;
  logic [6:0]  d2_out_opcode;
  logic [4:0]  d2_out_rd;
  logic [4:0]  d2_out_rs1;
  logic [4:0]  d2_out_rs2;
  logic [2:0]  d2_out_funct3;
  logic [6:0]  d2_out_funct7;
  logic [63:0] d2_out_imm;
  logic        d2_out_illegal;
  logic [2:0]  d2_count;
  logic [15:0] d2_illegal_cnt;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  logic [15:0] exp_ill = '0;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  instr_decode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  instr_decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(d2_flush),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_instr(d2_in_instr),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_fmt(d2_out_fmt), .out_opcode(d2_out_opcode), .out_rd(d2_out_rd),
    .out_rs1(d2_out_rs1), .out_rs2(d2_out_rs2), .out_funct3(d2_out_funct3),
    .out_funct7(d2_out_funct7), .out_imm(d2_out_imm), .out_illegal(d2_out_illegal),
    .count(d2_count), .illegal_cnt(d2_illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA tables: returns {fmt, imm32}.
  function automatic logic [34:0] model(input logic [31:0] w);
    logic [2:0]  f;
    logic [31:0] im;
    f  = 3'd7;
    im = 32'd0;
    if (w[6:0] == 7'h33) begin
      f = 3'd0;
    end else if (w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h67) begin
      f = 3'd1; im = {{20{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'h23) begin
      f = 3'd2; im = {{20{w[31]}}, w[31:25], w[11:7]};
    end else if (w[6:0] == 7'h63) begin
      f = 3'd3; im = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
      f = 3'd4; im = {w[31:12], 12'h000};
    end else if (w[6:0] == 7'h6F) begin
      f = 3'd5; im = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    end
    return {f, im};
  endfunction

  // Scoreboard monitor: inputs change just after rising edges, so the falling
  // edge sees the handshakes that the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    logic [34:0] m;
    if (!rst_n) begin
      sb.delete();
      exp_ill = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          pop_cnt++;
          check("pop_fmt", 64'(out_fmt), 64'(e.fmt));
          check("pop_imm", 64'(out_imm), 64'(e.imm));
          check("pop_fields", 64'({out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}),
                64'(e.word));
          check("pop_illegal", 64'(out_illegal), 64'(e.fmt == 3'd7));
        end
      end
      if (in_valid && in_ready) begin
        m = model(in_instr);
        sb.push_back({m[34:32], m[31:0], in_instr});
        if (m[34:32] == 3'd7 && exp_ill != 16'hFFFF) exp_ill = exp_ill + 16'd1;
      end
    end
  end

  // Present one word until it is accepted; returns one step after the edge.
  task automatic drive(input logic [31:0] w);
    logic r;
    int n;
    in_valid = 1'b1;
    in_instr = w;
    n = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 200) begin
        check("drive_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check(tag, 64'(count), 64'd0);
  endtask

  logic [31:0] table_w [14] = '{
    32'h00B50533, 32'h40B50533, 32'h0042A303, 32'hFE112E23,
    32'h000780E7, 32'h12345037, 32'hFFFFF097, 32'h00000013,
    32'h0000007F, 32'hFFFFFFFF, 32'h00000011, 32'h80000063,
    32'hFFFFFFEF, 32'h7FF00013
  };

  initial begin
    logic r;
    int n;
    int p0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_instr = '0; d2_out_ready = 1'b0; d2_flush = 1'b0;

    // reset values
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    check("rst_fmt", 64'(out_fmt), 64'd0);
    check("rst_imm", 64'(out_imm), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI x1,x2,-1
    in_valid = 1'b1; in_instr = 32'hFFF10093;
    @(negedge clk);
    check("addi_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_fmt", 64'(out_fmt), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd2);
    check("addi_funct3", 64'(out_funct3), 64'd0);
    check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    pop_one();
    check("addi_popped", 64'(count), 64'd0);

    // BEQ then JAL
    drive(32'hFE000EE3);
    drive(32'h001000EF);
    check("beq_fmt", 64'(out_fmt), 64'd3);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    pop_one();
    check("jal_fmt", 64'(out_fmt), 64'd5);
    check("jal_rd", 64'(out_rd), 64'd1);
    check("jal_imm", 64'(out_imm), 64'h00000800);
    pop_one();

    // first illegal word
    drive(32'h00000000);
    check("ill_fmt", 64'(out_fmt), 64'd7);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_imm", 64'(out_imm), 64'd0);
    check("ill_cnt", 64'(illegal_cnt), 64'd1);
    pop_one();

    // mixed formats and random words with the consumer always ready
    out_ready = 1'b1;
    foreach (table_w[i]) drive(table_w[i]);
    for (int i = 0; i < 16; i++) drive($urandom);
    wait_empty("mix_drained");
    check("mix_sb_empty", 64'(sb.size()), 64'd0);
    check("mix_ill_cnt", 64'(illegal_cnt), 64'(exp_ill));

    // fill to DEPTH, hold the fifth, then drain in order
    p0 = pop_cnt;
    drive(32'h00100093); drive(32'h00200113); drive(32'h00300193); drive(32'h00400213);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00500293;
    repeat (3) @(posedge clk);
    #1;
    check("full_held_count", 64'(count), 64'd4);
    check("full_head_stable", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while ((in_valid || count != 0) && n < 20) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) in_valid = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    check("full_pops", 64'(pop_cnt - p0), 64'd5);
    check("full_drained", 64'(count), 64'd0);

    // flush at count 3 with a concurrent illegal push
    drive(32'h00A00513); drive(32'h00B00593); drive(32'h00C00613);
    check("flush_pre_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ill_cnt", 64'(illegal_cnt), 64'(exp_ill));
    @(posedge clk); #1;
    check("flush_dropped", 64'(count), 64'd0);

    // saturate illegal_cnt with back-to-back push/pop
    in_valid = 1'b1; in_instr = 32'h00000000; out_ready = 1'b1;
    n = 0;
    while (illegal_cnt != 16'hFFFF && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    check("sat_reached", 64'(illegal_cnt), 64'hFFFF);
    check("sat_steady_count", 64'(count), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sat_hold", 64'(illegal_cnt), 64'hFFFF);
    wait_empty("sat_drained");

    // asynchronous reset in the middle of traffic
    drive(32'h00100093); drive(32'h00200113);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_ill_cnt", 64'(illegal_cnt), 64'd0);
    check("arst_fmt", 64'(out_fmt), 64'd0);
    check("arst_imm", 64'(out_imm), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_after_count", 64'(count), 64'd0);

    // XLEN=64 LUI
    d2_in_valid = 1'b1; d2_in_instr = 32'h800000B7;
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    check("x64_fmt", 64'(d2_out_fmt), 64'd4);
    check("x64_rd", 64'(d2_out_rd), 64'd1);
    check("x64_imm", d2_out_imm, 64'hFFFFFFFF80000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
